// File: rtl/dispatch_pkg.sv
// Shared sizes, slot types and index arithmetic for the dual request dispatcher.
package dispatch_pkg;

    localparam int REQ_N_DEF     = 12;
    localparam int PAYLOAD_W_DEF = 8;
    localparam int OUT_N_DEF     = $clog2(REQ_N_DEF);

    typedef logic [OUT_N_DEF-1:0]     idx_t;
    typedef logic [PAYLOAD_W_DEF-1:0] payload_t;

    // Both operands are already below n, so one conditional subtract wraps the sum.
    function automatic int wrap_add(input int idx, input int ptr, input int n);
        int sum;
        sum = idx + ptr;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dispatch_out_slot.sv
// One registered valid/ready output channel that reloads whenever it is open.
module dispatch_out_slot #(
    parameter int OUT_N     = 4,
    parameter int PAYLOAD_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ready,
    input  logic                 i_load_valid,
    input  logic [OUT_N-1:0]     i_load_idx,
    input  logic [PAYLOAD_W-1:0] i_load_data,
    output logic                 o_open,
    output logic                 o_valid,
    output logic [OUT_N-1:0]     o_idx,
    output logic [PAYLOAD_W-1:0] o_data
);

    logic                 valid_r;
    logic [OUT_N-1:0]     idx_r;
    logic [PAYLOAD_W-1:0] data_r;

    assign o_open  = !valid_r || i_ready;
    assign o_valid = valid_r;
    assign o_idx   = idx_r;
    assign o_data  = data_r;

    // Index and payload only move on a real load, so a stalled channel stays stable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_r <= 1'b0;
            idx_r   <= '0;
            data_r  <= '0;
        end else if (o_open) begin
            valid_r <= i_load_valid;
            if (i_load_valid) begin
                idx_r  <= i_load_idx;
                data_r <= i_load_data;
            end else begin
                idx_r  <= idx_r;
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/dual_priority_encoder.sv
// Finds the lowest and second-lowest set bits of a request vector.
module dual_priority_encoder #(
    parameter int REQ_N = 12,
    parameter int OUT_N = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] i_req,
    output logic [OUT_N-1:0] o_data_1,
    output logic             o_1_valid,
    output logic [OUT_N-1:0] o_data_2,
    output logic             o_2_valid
);

    logic [OUT_N-1:0] d1_s;
    logic [OUT_N-1:0] d2_s;
    logic             v1_s;
    logic             v2_s;

    // Ascending scan: the first hit is pick 1, the second hit is pick 2.
    always_comb begin
        d1_s = '0;
        d2_s = '0;
        v1_s = 1'b0;
        v2_s = 1'b0;
        for (int i = 0; i < REQ_N; i++) begin
            if (i_req[i] && !v1_s) begin
                d1_s = OUT_N'(i);
                v1_s = 1'b1;
            end else if (i_req[i] && !v2_s) begin
                d2_s = OUT_N'(i);
                v2_s = 1'b1;
            end else begin
                d2_s = d2_s;
            end
        end
    end

    assign o_data_1  = d1_s;
    assign o_1_valid = v1_s;
    assign o_data_2  = d2_s;
    assign o_2_valid = v2_s;

endmodule

// File: rtl/dual_req_dispatcher.sv
// Pending-request bitmap with payload RAM feeding two valid/ready channels.
// Defining DUAL_DISPATCH_RR_EN switches fixed lowest-index priority to round-robin.
module dual_req_dispatcher
    import dispatch_pkg::*;
#(
    parameter int REQ_N     = REQ_N_DEF,
    parameter int OUT_N     = $clog2(REQ_N),
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [OUT_N-1:0]     i_wr_idx,
    input  logic [PAYLOAD_W-1:0] i_wr_data,
    output logic                 o_valid_0,
    output logic [OUT_N-1:0]     o_idx_0,
    output logic [PAYLOAD_W-1:0] o_data_0,
    input  logic                 i_ready_0,
    output logic                 o_valid_1,
    output logic [OUT_N-1:0]     o_idx_1,
    output logic [PAYLOAD_W-1:0] o_data_1,
    input  logic                 i_ready_1,
    output logic [REQ_N-1:0]     o_pending,
    output logic                 o_busy
);

    logic [REQ_N-1:0]     pending_r;
    logic [REQ_N-1:0]     pending_nxt_s;
    logic [REQ_N-1:0]     wr_mask_s;
    logic [REQ_N-1:0]     clr_mask_s;
    logic [REQ_N-1:0]     hold_mask_s;
    logic [REQ_N-1:0]     avail_s;
    logic [REQ_N-1:0]     enc_req_s;
    logic [PAYLOAD_W-1:0] ram_r [REQ_N];
    logic                 wr_ok_s;
    logic [OUT_N-1:0]     enc_d1_s;
    logic [OUT_N-1:0]     enc_d2_s;
    logic                 enc_v1_s;
    logic                 enc_v2_s;
    logic [OUT_N-1:0]     pick1_idx_s;
    logic [OUT_N-1:0]     pick2_idx_s;
    logic                 open0_s;
    logic                 open1_s;
    logic                 ld1_valid_s;
    logic [OUT_N-1:0]     ld1_idx_s;
    logic [PAYLOAD_W-1:0] ld0_data_s;
    logic [PAYLOAD_W-1:0] ld1_data_s;

    assign wr_ok_s = i_wr_en && (int'(i_wr_idx) < REQ_N);

    // A slot re-requested while parked in a stalled channel must not be granted to the other channel.
    always_comb begin
        hold_mask_s = '0;
        hold_mask_s[o_idx_0] = o_valid_0 & ~i_ready_0;
        hold_mask_s[o_idx_1] = hold_mask_s[o_idx_1] | (o_valid_1 & ~i_ready_1);
    end

    assign avail_s = pending_r & ~hold_mask_s;

`ifdef DUAL_DISPATCH_RR_EN
    logic [OUT_N-1:0] rr_ptr_r;
    logic [OUT_N-1:0] last_idx_s;
    logic             any_load_s;

    // Rotate so the slot at rr_ptr_r lands at encoder bit 0.
    always_comb begin
        enc_req_s = '0;
        for (int i = 0; i < REQ_N; i++) begin
            enc_req_s[i] = avail_s[OUT_N'(wrap_add(i, int'(rr_ptr_r), REQ_N))];
        end
    end

    assign pick1_idx_s = OUT_N'(wrap_add(int'(enc_d1_s), int'(rr_ptr_r), REQ_N));
    assign pick2_idx_s = OUT_N'(wrap_add(int'(enc_d2_s), int'(rr_ptr_r), REQ_N));
    assign any_load_s  = (open0_s & enc_v1_s) | (open1_s & ld1_valid_s);
    assign last_idx_s  = (open1_s && ld1_valid_s) ? ld1_idx_s : pick1_idx_s;

    // Pointer moves just past the last slot granted this cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr_r <= '0;
        end else if (any_load_s) begin
            rr_ptr_r <= OUT_N'(wrap_add(int'(last_idx_s), 1, REQ_N));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    assign enc_req_s   = avail_s;
    assign pick1_idx_s = enc_d1_s;
    assign pick2_idx_s = enc_d2_s;
`endif

    dual_priority_encoder #(
        .REQ_N (REQ_N),
        .OUT_N (OUT_N)
    ) u_enc (
        .i_req     (enc_req_s),
        .o_data_1  (enc_d1_s),
        .o_1_valid (enc_v1_s),
        .o_data_2  (enc_d2_s),
        .o_2_valid (enc_v2_s)
    );

    // Channel 1 takes the second pick only when channel 0 is also loading.
    always_comb begin
        if (open0_s) begin
            ld1_valid_s = enc_v2_s;
            ld1_idx_s   = pick2_idx_s;
        end else begin
            ld1_valid_s = enc_v1_s;
            ld1_idx_s   = pick1_idx_s;
        end
        clr_mask_s = '0;
        clr_mask_s[pick1_idx_s] = open0_s & enc_v1_s;
        clr_mask_s[ld1_idx_s]   = clr_mask_s[ld1_idx_s] | (open1_s & ld1_valid_s);
        if (wr_ok_s) begin
            wr_mask_s = '0;
            wr_mask_s[i_wr_idx] = 1'b1;
        end else begin
            wr_mask_s = '0;
        end
    end

    // Payload is read before the same-edge write lands, so a collided load sees the old value.
    assign ld0_data_s    = ram_r[pick1_idx_s];
    assign ld1_data_s    = ram_r[ld1_idx_s];
    assign pending_nxt_s = (pending_r & ~clr_mask_s) | wr_mask_s;

    // Pending bitmap update.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Payload RAM keeps its contents through reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok_s) begin
            ram_r[i_wr_idx] <= i_wr_data;
        end
    end

    dispatch_out_slot #(
        .OUT_N     (OUT_N),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_slot_0 (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ready      (i_ready_0),
        .i_load_valid (enc_v1_s),
        .i_load_idx   (pick1_idx_s),
        .i_load_data  (ld0_data_s),
        .o_open       (open0_s),
        .o_valid      (o_valid_0),
        .o_idx        (o_idx_0),
        .o_data       (o_data_0)
    );

    dispatch_out_slot #(
        .OUT_N     (OUT_N),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_slot_1 (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ready      (i_ready_1),
        .i_load_valid (ld1_valid_s),
        .i_load_idx   (ld1_idx_s),
        .i_load_data  (ld1_data_s),
        .o_open       (open1_s),
        .o_valid      (o_valid_1),
        .o_idx        (o_idx_1),
        .o_data       (o_data_1)
    );

    assign o_pending = pending_r;
    assign o_busy    = (|pending_r) | o_valid_0 | o_valid_1;

endmodule

// File: tb/tb_dual_req_dispatcher.sv
// Directed bench for dual_req_dispatcher; the round-robin step runs only when DUAL_DISPATCH_RR_EN is defined.
module tb_dual_req_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_data;
    logic        valid_0;
    logic [3:0]  idx_0;
    logic [7:0]  data_0;
    logic        ready_0;
    logic        valid_1;
    logic [3:0]  idx_1;
    logic [7:0]  data_1;
    logic        ready_1;
    logic [11:0] pending;
    logic        busy;

    int checks;
    int errors;

    dual_req_dispatcher dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_idx  (wr_idx),
        .i_wr_data (wr_data),
        .o_valid_0 (valid_0),
        .o_idx_0   (idx_0),
        .o_data_0  (data_0),
        .i_ready_0 (ready_0),
        .o_valid_1 (valid_1),
        .o_idx_1   (idx_1),
        .o_data_1  (data_1),
        .i_ready_1 (ready_1),
        .o_pending (pending),
        .o_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_data = 8'h00;
        ready_0 = 1'b1;
        ready_1 = 1'b1;
        step();
        step();
        chk("rst_valid_0", 32'(valid_0), 32'd0);
        chk("rst_valid_1", 32'(valid_1), 32'd0);
        chk("rst_idx_0", 32'(idx_0), 32'd0);
        chk("rst_data_1", 32'(data_1), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Two writes, one per cycle: each is granted two cycles after its write.
        wr(4'd3, 8'hA3);
        step();
        chk("t1_pend_a", 32'(pending), 32'h008);
        chk("t1_v0_a", 32'(valid_0), 32'd0);
        wr(4'd7, 8'hB7);
        step();
        chk("t1_v0_b", 32'(valid_0), 32'd1);
        chk("t1_idx0_b", 32'(idx_0), 32'd3);
        chk("t1_data0_b", 32'(data_0), 32'hA3);
        chk("t1_v1_b", 32'(valid_1), 32'd0);
        chk("t1_pend_b", 32'(pending), 32'h080);
        wr_en = 1'b0;
        step();
        chk("t1_idx0_c", 32'(idx_0), 32'd7);
        chk("t1_data0_c", 32'(data_0), 32'hB7);
        chk("t1_pend_c", 32'(pending), 32'h000);
        step();
        chk("t1_v0_d", 32'(valid_0), 32'd0);
        chk("t1_busy_d", 32'(busy), 32'd0);

        // Out-of-range write index is ignored.
        wr(4'd13, 8'hFF);
        step();
        wr_en = 1'b0;
        chk("bad_pend", 32'(pending), 32'h000);
        step();
        chk("bad_v0", 32'(valid_0), 32'd0);
        chk("bad_v1", 32'(valid_1), 32'd0);

        // Channel 0 stalled; channel 1 drains the rest.
        ready_0 = 1'b0;
        ready_1 = 1'b1;
        wr(4'd0, 8'h10);
        step();
        wr(4'd1, 8'h11);
        step();
        chk("t2_v0_a", 32'(valid_0), 32'd1);
        chk("t2_idx0_a", 32'(idx_0), 32'd0);
        chk("t2_v1_a", 32'(valid_1), 32'd0);
        wr(4'd2, 8'h12);
        step();
        chk("t2_idx0_b", 32'(idx_0), 32'd0);
        chk("t2_v1_b", 32'(valid_1), 32'd1);
        chk("t2_idx1_b", 32'(idx_1), 32'd1);
        chk("t2_data1_b", 32'(data_1), 32'h11);
        chk("t2_pend_b", 32'(pending), 32'h004);
        wr_en = 1'b0;
        step();
        chk("t2_v0_c", 32'(valid_0), 32'd1);
        chk("t2_idx0_c", 32'(idx_0), 32'd0);
        chk("t2_data0_c", 32'(data_0), 32'h10);
        chk("t2_idx1_c", 32'(idx_1), 32'd2);
        chk("t2_data1_c", 32'(data_1), 32'h12);
        chk("t2_pend_c", 32'(pending), 32'h000);
        step();
        chk("t2_v1_d", 32'(valid_1), 32'd0);
        chk("t2_idx0_d", 32'(idx_0), 32'd0);
        chk("t2_data0_d", 32'(data_0), 32'h10);
        ready_0 = 1'b1;
        step();
        chk("t2_v0_e", 32'(valid_0), 32'd0);
        chk("t2_busy_e", 32'(busy), 32'd0);

        // Fill every slot behind stalled channels, then release both.
        ready_0 = 1'b0;
        ready_1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wr(4'(k), 8'(8'h40 + 8'(k)));
            step();
        end
        wr_en = 1'b0;
        chk("t3_pend_full", 32'(pending), 32'hFFC);
        chk("t3_idx0_0", 32'(idx_0), 32'd0);
        chk("t3_data0_0", 32'(data_0), 32'h40);
        chk("t3_idx1_0", 32'(idx_1), 32'd1);
        chk("t3_data1_0", 32'(data_1), 32'h41);
        ready_0 = 1'b1;
        ready_1 = 1'b1;
        for (int p = 1; p < 6; p++) begin
            step();
            chk("t3_v0", 32'(valid_0), 32'd1);
            chk("t3_idx0", 32'(idx_0), 32'(2 * p));
            chk("t3_data0", 32'(data_0), 32'(8'h40 + 8'(2 * p)));
            chk("t3_v1", 32'(valid_1), 32'd1);
            chk("t3_idx1", 32'(idx_1), 32'(2 * p + 1));
            chk("t3_data1", 32'(data_1), 32'(8'h40 + 8'(2 * p + 1)));
        end
        chk("t3_pend_end", 32'(pending), 32'h000);
        chk("t3_busy_end", 32'(busy), 32'd1);
        step();
        chk("t3_v0_idle", 32'(valid_0), 32'd0);
        chk("t3_v1_idle", 32'(valid_1), 32'd0);
        chk("t3_busy_idle", 32'(busy), 32'd0);

        // Write collides with the load of the same slot.
        wr(4'd5, 8'h50);
        step();
        chk("t4_pend_a", 32'(pending), 32'h020);
        wr(4'd5, 8'h55);
        step();
        chk("t4_v0_b", 32'(valid_0), 32'd1);
        chk("t4_idx0_b", 32'(idx_0), 32'd5);
        chk("t4_data0_b", 32'(data_0), 32'h50);
        chk("t4_pend_b", 32'(pending), 32'h020);
        wr_en = 1'b0;
        step();
        chk("t4_idx0_c", 32'(idx_0), 32'd5);
        chk("t4_data0_c", 32'(data_0), 32'h55);
        chk("t4_v1_c", 32'(valid_1), 32'd0);
        chk("t4_pend_c", 32'(pending), 32'h000);
        step();
        chk("t4_v0_d", 32'(valid_0), 32'd0);

        // Stalled full channels, overwrite of a pending slot, then reset.
        ready_0 = 1'b0;
        ready_1 = 1'b0;
        wr(4'd8, 8'h81);
        step();
        wr(4'd9, 8'h91);
        step();
        wr(4'd10, 8'hA1);
        step();
        chk("t5_idx0", 32'(idx_0), 32'd8);
        chk("t5_idx1", 32'(idx_1), 32'd9);
        chk("t5_pend", 32'(pending), 32'h400);
        wr(4'd10, 8'hA2);
        step();
        chk("t5_pend_ovw", 32'(pending), 32'h400);
        chk("t5_idx0_hold", 32'(idx_0), 32'd8);
        chk("t5_data1_hold", 32'(data_1), 32'h91);
        wr_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_v0_rst", 32'(valid_0), 32'd0);
        chk("t5_v1_rst", 32'(valid_1), 32'd0);
        chk("t5_pend_rst", 32'(pending), 32'h000);
        chk("t5_idx0_rst", 32'(idx_0), 32'd0);
        chk("t5_data1_rst", 32'(data_1), 32'h00);
        chk("t5_busy_rst", 32'(busy), 32'd0);

`ifdef DUAL_DISPATCH_RR_EN
        // Channel 0 parks slot 11; channel 1 alternates between slots 0 and 1.
        wr(4'd11, 8'hE1);
        step();
        wr(4'd10, 8'hE0);
        step();
        wr(4'd0, 8'hC0);
        step();
        chk("rr_idx0_park", 32'(idx_0), 32'd11);
        chk("rr_idx1_park", 32'(idx_1), 32'd10);
        wr(4'd1, 8'hC1);
        step();
        chk("rr_pend", 32'(pending), 32'h003);
        ready_1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wr(4'(n % 2), 8'(8'hC0 + 8'(n % 2)));
            step();
            chk("rr_v1", 32'(valid_1), 32'd1);
            chk("rr_idx1", 32'(idx_1), 32'(n % 2));
        end
        wr_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
